// File: rtl/negator_arbiter_pkg.sv
// Shared constants for the negation-unit arbiter: FSM encoding, default sizes, id width helper.
package negator_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 2;

    // Width of a requester index; never below one bit so a 2-way arbiter still has a real ID.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/negator_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo NREQ.
// No state; any=0 when no request is pending.
module rr_priority_picker
    import negator_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = id_width(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IDW-1:0]  id,
    output logic            any
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;

    always_comb begin
        onehot = '0;
        id     = '0;
        any    = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            // ptr + i never reaches 2*NREQ, so one conditional subtract is a full modulo.
            sum = {1'b0, ptr} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (!any && req[idx]) begin
                any         = 1'b1;
                onehot[idx] = 1'b1;
                id          = idx;
            end
        end
    end

endmodule

// File: rtl/negator_arbiter.sv
// Round-robin arbiter sharing one combinational negation unit; 3 cycles per operation, DONE pulses one-hot.
// Define NEG_OVERFLOW_EN to add the OVERFLOW output (operand was the most-negative value).
module negator_arbiter
    import negator_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*WIDTH-1:0] OPERAND,
    output logic [NREQ-1:0]       GNT,
    output logic [WIDTH-1:0]      NEG_IN,
    input  logic [WIDTH-1:0]      NEG_OUT,
    output logic [WIDTH-1:0]      RESULT,
    output logic [NREQ-1:0]       DONE,
`ifdef NEG_OVERFLOW_EN
    output logic                  OVERFLOW,
`endif
    output logic                  BUSY
);

    localparam int IDW = id_width(NREQ);

    state_t           state;
    logic [IDW-1:0]   id;
    logic [IDW-1:0]   ptr;
    logic [NREQ-1:0]  win_onehot;
    logic [IDW-1:0]   win_id;
    logic             win_any;
    logic [WIDTH-1:0] operand_arr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            operand_arr[i] = OPERAND[i*WIDTH +: WIDTH];
        end
    end

    rr_priority_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .req    (REQ),
        .ptr    (ptr),
        .onehot (win_onehot),
        .id     (win_id),
        .any    (win_any)
    );

`ifdef NEG_OVERFLOW_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state  <= IDLE;
            id     <= '0;
            ptr    <= '0;
            GNT    <= '0;
            NEG_IN <= '0;
            RESULT <= '0;
            DONE   <= '0;
            BUSY   <= 1'b0;
`ifdef NEG_OVERFLOW_EN
            OVERFLOW <= 1'b0;
`endif
        end else begin
            DONE <= '0;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        id     <= win_id;
                        NEG_IN <= operand_arr[win_id];
                        GNT    <= win_onehot;
                        BUSY   <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                // The shared unit is combinational with a small delay; give it a whole cycle.
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    RESULT <= NEG_OUT;
`ifdef NEG_OVERFLOW_EN
                    OVERFLOW <= (NEG_IN == MOST_NEG);
`endif
                    DONE  <= GNT;
                    GNT   <= '0;
                    BUSY  <= 1'b0;
                    ptr   <= (id == IDW'(NREQ-1)) ? '0 : id + IDW'(1);
                    state <= IDLE;
                end
                default: begin
                    GNT   <= '0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_negator_arbiter.sv
// Directed bench for negator_arbiter with a behavioural shared negation unit (1 time-unit delay).
module tb_negator_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [15:0] operand;
    logic [1:0]  gnt;
    logic [7:0]  neg_in;
    logic [7:0]  neg_out;
    logic [7:0]  result;
    logic [1:0]  done;
    logic        busy;
`ifdef NEG_OVERFLOW_EN
    logic        overflow;
`endif

    int total = 0;
    int bad   = 0;

    negator_arbiter #(.NREQ(2), .WIDTH(8)) dut (
        .CLK     (clk),
        .RESET   (rst_n),
        .REQ     (req),
        .OPERAND (operand),
        .GNT     (gnt),
        .NEG_IN  (neg_in),
        .NEG_OUT (neg_out),
        .RESULT  (result),
        .DONE    (done),
`ifdef NEG_OVERFLOW_EN
        .OVERFLOW(overflow),
`endif
        .BUSY    (busy)
    );

    assign #1 neg_out = ~neg_in + 8'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; req = 2'b00; operand = 16'h0000;
        #12;
        total++; if (gnt !== 2'b00)   begin bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        total++; if (neg_in !== 8'h00) begin bad++; $display("FAIL reset_neg_in: got %h want 00", neg_in); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result: got %h want 00", result); end
        total++; if (done !== 2'b00)  begin bad++; $display("FAIL reset_done: got %b want 00", done); end
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [1:0] eg, ed;
        req = 2'b11; operand = {8'h02, 8'h01};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            eg = (c == 0 || c == 1) ? 2'b01 : (c == 3 || c == 4) ? 2'b10 : 2'b00;
            ed = (c == 2) ? 2'b01 : (c == 5) ? 2'b10 : 2'b00;
            total++; if (gnt !== eg)  begin bad++; $display("FAIL b2b_gnt[%0d]: got %b want %b", c, gnt, eg); end
            total++; if (done !== ed) begin bad++; $display("FAIL b2b_done[%0d]: got %b want %b", c, done, ed); end
            if (c == 2) begin
                total++; if (result !== 8'hFF) begin bad++; $display("FAIL b2b_result0: got %h want ff", result); end
                req = 2'b10;
            end
            if (c == 5) begin
                total++; if (result !== 8'hFE) begin bad++; $display("FAIL b2b_result1: got %h want fe", result); end
                req = 2'b00;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        logic [1:0] eo;
        logic [7:0] er;
        req = 2'b11; operand = {8'h22, 8'h11};
        for (int op = 0; op < 6; op++) begin
            eo = (op % 2 == 0) ? 2'b01 : 2'b10;
            er = (op % 2 == 0) ? 8'hEF : 8'hDE;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (c < 2) begin
                    total++; if (gnt !== eo) begin bad++; $display("FAIL rr_gnt[%0d.%0d]: got %b want %b", op, c, gnt, eo); end
                end else begin
                    total++; if (done !== eo) begin bad++; $display("FAIL rr_done[%0d]: got %b want %b", op, done, eo); end
                    total++; if (result !== er) begin bad++; $display("FAIL rr_result[%0d]: got %h want %h", op, result, er); end
                    if (op == 5) req = 2'b00;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        req = 2'b01; operand = {8'h00, 8'h05};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c < 2) begin
                total++; if (gnt !== 2'b01) begin bad++; $display("FAIL single_gnt[%0d]: got %b want 01", c, gnt); end
                total++; if (done !== 2'b00) begin bad++; $display("FAIL single_early_done[%0d]: got %b want 00", c, done); end
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy[%0d]: got %b want 1", c, busy); end
            end else if (c == 2) begin
                total++; if (done !== 2'b01) begin bad++; $display("FAIL single_done: got %b want 01", done); end
                total++; if (gnt !== 2'b00) begin bad++; $display("FAIL single_gnt_clear: got %b want 00", gnt); end
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_clear: got %b want 0", busy); end
                total++; if (result !== 8'hFB) begin bad++; $display("FAIL single_result: got %h want fb", result); end
                req = 2'b00;
            end else begin
                total++; if (done !== 2'b00) begin bad++; $display("FAIL single_done_pulse: got %b want 00", done); end
                total++; if (result !== 8'hFB) begin bad++; $display("FAIL single_result_hold: got %h want fb", result); end
            end
        end
    endtask

    task automatic test_edges();
        logic [7:0] ops  [3] = '{8'h00, 8'h80, 8'h7F};
        logic [7:0] exps [3] = '{8'h00, 8'h80, 8'h81};
        logic       ovfs [3] = '{1'b0, 1'b1, 1'b0};
        for (int t = 0; t < 3; t++) begin
            req = 2'b01; operand = {8'h00, ops[t]};
            @(negedge clk);
            total++; if (neg_in !== ops[t]) begin bad++; $display("FAIL edge_neg_in[%0d]: got %h want %h", t, neg_in, ops[t]); end
            @(negedge clk);
            @(negedge clk);
            total++; if (result !== exps[t]) begin bad++; $display("FAIL edge_result[%0d]: got %h want %h", t, result, exps[t]); end
`ifdef NEG_OVERFLOW_EN
            total++; if (overflow !== ovfs[t]) begin bad++; $display("FAIL edge_overflow[%0d]: got %b want %b", t, overflow, ovfs[t]); end
`else
            if (ovfs[t]) begin end
`endif
            req = 2'b00;
            @(negedge clk);
        end
    endtask

    task automatic test_operand_hold();
        req = 2'b01; operand = {8'h00, 8'h03};
        @(negedge clk);
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL hold_gnt: got %b want 01", gnt); end
        operand = {8'h00, 8'h10};
        @(negedge clk);
        total++; if (neg_in !== 8'h03) begin bad++; $display("FAIL hold_neg_in: got %h want 03", neg_in); end
        @(negedge clk);
        total++; if (result !== 8'hFD) begin bad++; $display("FAIL hold_result: got %h want fd", result); end
        req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        req = 2'b01; operand = {8'h00, 8'h44};
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        total++; if (gnt !== 2'b00)    begin bad++; $display("FAIL mid_gnt: got %b want 00", gnt); end
        total++; if (done !== 2'b00)   begin bad++; $display("FAIL mid_done: got %b want 00", done); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL mid_result: got %h want 00", result); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        total++; if (neg_in !== 8'h00) begin bad++; $display("FAIL mid_neg_in: got %h want 00", neg_in); end
        req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        req = 2'b11; operand = {8'h09, 8'h06};
        @(negedge clk);
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL mid_fresh_gnt: got %b want 01", gnt); end
        @(negedge clk);
        @(negedge clk);
        total++; if (done !== 2'b01)   begin bad++; $display("FAIL mid_fresh_done: got %b want 01", done); end
        total++; if (result !== 8'hFA) begin bad++; $display("FAIL mid_fresh_result: got %h want fa", result); end
        req = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_fairness();
        test_single();
        test_edges();
        test_operand_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/negator_arbiter.md
Name: negator_arbiter

Overview:
- Shares one combinational two's-complement negation unit between NREQ requesters in the simple 8-bit processor, for example the ALU SUB path and the branch-offset path.
- Arbitrates round-robin and drives the shared unit's input.
- Waits one clock for the unit's output to settle, registers the result, and returns it to the granted requester with a done pulse.
- Sits between the requesters and the shared twoscomplement instance.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- REQ  input  NREQ  per-requester request level.
- OPERAND  input  NREQ*WIDTH  flattened operands; requester i occupies bits [i*WIDTH +: WIDTH].
- GNT  output  NREQ  one-hot grant.
- NEG_IN  output  WIDTH  operand driven to the shared negation unit.
- NEG_OUT  input  WIDTH  result from the shared negation unit.
- RESULT  output  WIDTH  registered negated value.
- DONE  output  NREQ  one-hot, one-cycle completion pulse.
- BUSY  output  1  high whenever the block is not in IDLE.

Behaviour:
- Reset (RESET low, asynchronous), all outputs zero:
  - GNT=0, NEG_IN=0, RESULT=0, DONE=0, BUSY=0.
  - state=IDLE, round-robin pointer PTR=0.
- States: IDLE -> ISSUE -> CAPTURE -> IDLE.
- IDLE:
  - If any REQ bit is high at the edge, pick a winner: the first set REQ bit searching upward from PTR, wrapping modulo NREQ.
  - Latch winner id into ID, operand into NEG_IN, set GNT[ID]; go to ISSUE.
  - If no REQ bit is high, stay in IDLE.
- ISSUE: hold GNT and NEG_IN stable for one full cycle so the shared unit (1 time-unit delay) settles; go to CAPTURE.
- CAPTURE:
  - RESULT<=NEG_OUT, DONE[ID]=1 for this cycle only, GNT cleared.
  - PTR<=(ID+1) mod NREQ; go to IDLE.
- Latency: REQ sampled high at edge k -> GNT high cycles k+1..k+2 -> DONE high cycle k+3 with RESULT valid from then on.
- Throughput: one operation per 3 cycles.
- Operand sampling:
  - The operand is latched once at grant; later OPERAND changes are ignored.
  - REQ dropping after grant does not abort: the operation completes and DONE still pulses.
- Requester obligations:
  - Hold REQ until DONE is seen.
  - Deassert REQ in the DONE cycle; otherwise it re-enters arbitration at the next IDLE edge.
- RESULT holds its value until the next CAPTURE.
- Arithmetic:
  - RESULT = (~operand + 1) mod 2^WIDTH.
  - 0x00 -> 0x00; 0x80 -> 0x80 (no wider result).
- Simultaneous requests: exactly one grant; the others wait. Every continuously asserted requester is served within NREQ operations (fairness).
- Reset mid-operation: immediate return to IDLE with all outputs zero. The in-flight result is lost and no DONE is issued.

Optional Feature:
- Macro: NEG_OVERFLOW_EN.
- Defined:
  - Adds output OVERFLOW (1 bit), registered in CAPTURE alongside RESULT.
  - OVERFLOW=1 when the latched operand equals the most-negative value (only MSB set, 0x80 for WIDTH=8); else 0.
  - Reset value 0.
- Undefined: no OVERFLOW port and no associated logic.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, ISSUE=2'd1, CAPTURE=2'd2.
  - Default WIDTH=8 and NREQ=2 constants.
  - clog2-based id width for ID and PTR.
- Sub-module rr_priority_picker: combinational; REQ and PTR in; one-hot winner and binary ID out. Reused by later shared-resource arbiters.

Test Plan:
- Reset, then REQ=01, OPERAND[0]=8'h05 -> GNT=01 for 2 cycles; DONE=01 three cycles after request; RESULT=8'hFB.
- REQ=11 held, OPERAND0=8'h01, OPERAND1=8'h02 -> requester 0 served first (RESULT 8'hFF), then requester 1 (RESULT 8'hFE); DONE pulses 3 cycles apart; never two GNT bits high.
- Edge values 8'h00 -> 8'h00; 8'h80 -> 8'h80 (with NEG_OVERFLOW_EN: OVERFLOW=1); 8'h7F -> 8'h81 (OVERFLOW=0).
- Operand changed to 8'h10 one cycle after grant of 8'h03 -> RESULT=8'hFD, not 8'hF0.
- RESET asserted low during ISSUE -> GNT, DONE, RESULT, BUSY all 0 immediately; after release, a fresh request completes normally with PTR=0.
- REQ=11 held for 6 operations -> grants alternate 0,1,0,1,0,1, confirming round-robin fairness and PTR wrap.
